// File: rtl/oa_wb_pkg.sv
// Shared types for the OA tile writeback block: FSM states, ICB bus structs and the
// per-word byte-mask helper.
package oa_wb_pkg;

    localparam int VLEN_DFLT     = 16;
    localparam int WORDS_PER_VEC = VLEN_DFLT / 4;
    localparam int ICB_AW        = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic              valid;
        logic [ICB_AW-1:0] addr;
        logic              read;
        logic [31:0]       wdata;
        logic [3:0]        wmask;
        logic [1:0]        size;
    } icb_cmd_m_t;

    typedef struct packed {
        logic ready;
    } icb_cmd_s_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } icb_rsp_s_t;

    typedef struct packed {
        logic ready;
    } icb_rsp_m_t;

    // Byte b of word w is live when its lane index is below the column count.
    function automatic logic [3:0] word_mask(input int unsigned w, input int unsigned n_cols);
        logic [3:0] m;
        m = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            m[b] = ((4 * w + b) < n_cols);
        end
        return m;
    endfunction

endpackage

// File: rtl/oa_tile_writeback_vec_fifo.sv
// Synchronous vector FIFO with occupancy count; push while full and pop while empty
// are ignored.
module vec_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]               count_q, count_d;
    logic                        push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/oa_tile_writeback.sv
// OA tile writeback: buffers int8 row vectors and writes them as masked 32-bit ICB stores.
// Optional perf counters are built when OA_WB_PERF_EN is defined.
module oa_tile_writeback
    import oa_wb_pkg::*;
#(
    parameter int VLEN       = VLEN_DFLT,
    parameter int REG_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      init_cfg,
    input  logic [REG_WIDTH-1:0]      base_addr,
    input  logic [REG_WIDTH-1:0]      row_stride,
    input  logic [REG_WIDTH-1:0]      n_rows,
    input  logic [$clog2(VLEN+1)-1:0] n_cols,
    input  logic                      in_valid,
    input  logic [8*VLEN-1:0]         in_vec_s8,
    output logic                      in_ready,
    output icb_cmd_m_t                icb_cmd_m,
    input  icb_cmd_s_t                icb_cmd_s,
    input  icb_rsp_s_t                icb_rsp_s,
    output icb_rsp_m_t                icb_rsp_m,
    output logic                      busy,
    output logic                      tile_done,
    output logic [2:0]                err
`ifdef OA_WB_PERF_EN
    ,
    output logic [31:0]               perf_stall_cyc,
    output logic [31:0]               perf_wr_cnt
`endif
);

    localparam int NW = VLEN / 4;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW = $clog2(VLEN + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);

    wb_state_t              state_q, state_d;
    logic [REG_WIDTH-1:0]   base_q, stride_q, nrows_q, row_q, row_off_q;
    logic [CW-1:0]          ncols_q;
    logic [WW-1:0]          word_q, last_w_q;
    logic [OW-1:0]          outst_q;
    logic [2:0]             err_q;

    logic                   fifo_full, fifo_empty;
    logic [8*VLEN-1:0]      fifo_head;
    logic [$clog2(FIFO_DEPTH+1)-1:0] unused_fifo_cnt;
    logic                   unused_rsp;
    logic                   start, push, pop, cmd_vld, accept, rsp_ok, last_word, last_row;

    assign busy      = (state_q != IDLE);
    assign in_ready  = busy && !fifo_full;
    assign start     = (state_q == IDLE) && init_cfg;
    assign push      = in_valid && in_ready;
    assign cmd_vld   = (state_q == RUN) && !fifo_empty && (outst_q != OW'(MAX_OUTST));
    assign accept    = cmd_vld && icb_cmd_s.ready;
    assign last_word = (word_q == last_w_q);
    assign last_row  = (row_q == nrows_q - 1'b1);
    assign pop       = accept && last_word;
    // Responses with nothing outstanding (e.g. stragglers after a reset) are dropped.
    assign rsp_ok    = icb_rsp_s.valid && (outst_q != '0);
    assign err       = err_q;
    assign unused_rsp = ^icb_rsp_s.rdata;
    assign icb_rsp_m.ready = 1'b1;

    vec_fifo #(
        .WIDTH (8 * VLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_vec_s8),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_fifo_cnt)
    );

    always_comb begin
        icb_cmd_m       = '0;
        icb_cmd_m.valid = cmd_vld;
        icb_cmd_m.addr  = ICB_AW'(base_q + row_off_q + REG_WIDTH'({word_q, 2'b00}));
        icb_cmd_m.read  = 1'b0;
        icb_cmd_m.wdata = fifo_head[32*word_q +: 32];
        icb_cmd_m.wmask = word_mask(32'(word_q), 32'(ncols_q));
        icb_cmd_m.size  = 2'b10;
    end

    always_comb begin
        state_d   = state_q;
        tile_done = 1'b0;
        case (state_q)
            IDLE:  if (init_cfg) state_d = (n_rows == '0) ? DRAIN : RUN;
            RUN:   if (pop && last_row) state_d = DRAIN;
            DRAIN: if (outst_q == '0) begin
                state_d   = IDLE;
                tile_done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outst_q <= '0;
        end else begin
            case ({accept, rsp_ok})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
        end
    end

    // Row offset is accumulated per finished row instead of multiplying row*stride.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q    <= '0;
            stride_q  <= '0;
            nrows_q   <= '0;
            ncols_q   <= '0;
            last_w_q  <= '0;
            row_q     <= '0;
            row_off_q <= '0;
            word_q    <= '0;
            err_q     <= '0;
        end else if (start) begin
            base_q    <= base_addr;
            stride_q  <= row_stride;
            nrows_q   <= n_rows;
            ncols_q   <= n_cols;
            last_w_q  <= WW'((n_cols - 1'b1) >> 2);
            row_q     <= '0;
            row_off_q <= '0;
            word_q    <= '0;
            err_q     <= '0;
        end else begin
            if (accept) begin
                if (last_word) begin
                    word_q    <= '0;
                    row_q     <= row_q + 1'b1;
                    row_off_q <= row_off_q + stride_q;
                end else begin
                    word_q <= word_q + 1'b1;
                end
            end
            err_q <= err_q | {rsp_ok && icb_rsp_s.err,
                              in_valid && busy && fifo_full,
                              init_cfg && busy};
        end
    end

`ifdef OA_WB_PERF_EN
    logic [31:0] stall_q, wr_q;

    assign perf_stall_cyc = stall_q;
    assign perf_wr_cnt    = wr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
            wr_q    <= '0;
        end else if (start) begin
            stall_q <= '0;
            wr_q    <= '0;
        end else begin
            if (cmd_vld && !icb_cmd_s.ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (accept && (wr_q != '1)) wr_q <= wr_q + 1'b1;
        end
    end
`endif

endmodule
